// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types and pipeline-control helpers
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_enable;
    logic ifid_flush;
    logic idex_enable;
    logic idex_flush;
    logic exmem_enable;
    logic exmem_flush;
    logic memwb_enable;
  } pipe_ctrl_t;

  // Rules applied once no data access is outstanding; the order is the priority.
  function automatic pipe_ctrl_t run_rules(input logic halt_mem, input logic branch,
                                           input logic lu, input logic ihit);
    pipe_ctrl_t c;
    c = '0;
    if (halt_mem) begin
      c.ifid_flush   = 1'b1;
      c.idex_flush   = 1'b1;
      c.exmem_flush  = 1'b1;
      c.memwb_enable = 1'b1;
    end else if (branch) begin
      c.pc_en        = 1'b1;
      c.ifid_flush   = 1'b1;
      c.idex_flush   = 1'b1;
      c.exmem_enable = 1'b1;
      c.memwb_enable = 1'b1;
    end else if (lu) begin
      c.idex_flush   = 1'b1;
      c.exmem_enable = 1'b1;
      c.memwb_enable = 1'b1;
    end else if (!ihit) begin
      c.ifid_flush   = 1'b1;
      c.idex_enable  = 1'b1;
      c.exmem_enable = 1'b1;
      c.memwb_enable = 1'b1;
    end else begin
      c.pc_en        = 1'b1;
      c.ifid_enable  = 1'b1;
      c.idex_enable  = 1'b1;
      c.exmem_enable = 1'b1;
      c.memwb_enable = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline latch control: dmem waits, redirects, load-use, fetch misses, halt
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_MEM,
  input  logic             dmemWEN_MEM,
  input  logic             halt_MEM,
  input  logic             memtoReg_EX,
  input  regbits_t         final_wsel_EX,
  input  regbits_t         rs_ID,
  input  regbits_t         rt_ID,
  input  logic             uses_rt_ID,
  input  logic             branch_taken_EX,
  output logic             pc_en,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             exmem_flush,
  output logic             memwb_enable,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirects
);

  hazard_state_t state, next_state;
  pipe_ctrl_t    ctrl;
  logic          lu;
  logic          pend_miss;
  logic          rules_active;
  logic          stall_inc;
  logic          redirect_inc;

  assign lu = memtoReg_EX && (final_wsel_EX != '0) &&
              ((final_wsel_EX == rs_ID) || (uses_rt_ID && (final_wsel_EX == rt_ID)));
  assign pend_miss = (dmemREN_MEM || dmemWEN_MEM) && !dhit;

  // The normal rule set applies in RUN once no access is missing, and on the DWAIT exit cycle.
  assign rules_active = ((state == RUN) && !pend_miss) || ((state == DWAIT) && dhit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (pend_miss)     next_state = DWAIT;
        else if (halt_MEM) next_state = HALT;
      end
      DWAIT: begin
        if (dhit) next_state = halt_MEM ? HALT : RUN;
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    ctrl   = '0;
    halted = 1'b0;
    if (!nRST) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (state == HALT) begin
      halted = 1'b1;
    end else if (rules_active) begin
      ctrl = run_rules(halt_MEM, branch_taken_EX, lu, ihit);
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_enable  = ctrl.ifid_enable;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_enable  = ctrl.idex_enable;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_enable = ctrl.exmem_enable;
  assign exmem_flush  = ctrl.exmem_flush;
  assign memwb_enable = ctrl.memwb_enable;

  assign stall_inc    = nRST && (state != HALT) && !ctrl.pc_en;
  assign redirect_inc = nRST && rules_active && !halt_MEM && branch_taken_EX;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (redirect_inc),
    .count (redirects)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, dmemREN_MEM, dmemWEN_MEM, halt_MEM, memtoReg_EX;
  logic [4:0]       final_wsel_EX, rs_ID, rt_ID;
  logic             uses_rt_ID, branch_taken_EX;
  logic             pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic             exmem_enable, exmem_flush, memwb_enable, halted;
  logic [CNT_W-1:0] stall_cycles, redirects;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_MEM(dmemREN_MEM), .dmemWEN_MEM(dmemWEN_MEM), .halt_MEM(halt_MEM),
    .memtoReg_EX(memtoReg_EX), .final_wsel_EX(final_wsel_EX), .rs_ID(rs_ID),
    .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .branch_taken_EX(branch_taken_EX),
    .pc_en(pc_en), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .halted(halted),
    .stall_cycles(stall_cycles), .redirects(redirects)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dmemREN_MEM = 1'b0; dmemWEN_MEM = 1'b0;
    halt_MEM = 1'b0; memtoReg_EX = 1'b0; final_wsel_EX = '0; rs_ID = '0;
    rt_ID = '0; uses_rt_ID = 1'b0; branch_taken_EX = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle();
    tick(); tick();
    nRST = 1'b1;
    #1;
  endtask

  // Control vector packed as {pc_en,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb_en}
  function automatic logic [7:0] ctl();
    return {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
            exmem_enable, exmem_flush, memwb_enable};
  endfunction

  initial begin
    idle();
    nRST = 1'b0;
    #1;
    check("reset_ctl", ctl(), 8'b0010_1010);
    check("reset_halted", halted, 0);
    for (int i = 0; i < 3; i++) tick();
    check("reset_ctl_held", ctl(), 8'b0010_1010);
    check("reset_stall", stall_cycles, 0);
    nRST = 1'b1;
    #1;
    check("run_all_en", ctl(), 8'b1101_0101);
    tick();
    check("run_no_stall_cnt", stall_cycles, 0);

    // load-use on rs: one bubble, then clear once the bubble reaches EX
    memtoReg_EX = 1'b1; final_wsel_EX = 5'd8; rs_ID = 5'd8;
    #1;
    check("lu_rs_ctl", ctl(), 8'b0000_1101);
    tick();
    memtoReg_EX = 1'b0;
    #1;
    check("lu_after_bubble", ctl(), 8'b1101_0101);
    check("lu_stall_cnt", stall_cycles, 1);
    memtoReg_EX = 1'b1; final_wsel_EX = 5'd0; rs_ID = 5'd0;
    #1;
    check("lu_r0_no_stall", pc_en, 1);
    final_wsel_EX = 5'd8; rs_ID = 5'd3; rt_ID = 5'd8; uses_rt_ID = 1'b0;
    #1;
    check("lu_rt_unused", pc_en, 1);
    uses_rt_ID = 1'b1;
    #1;
    check("lu_rt_used", ctl(), 8'b0000_1101);
    idle();
    #1;
    check("ifetch_miss_ihit1", pc_en, 1);
    ihit = 1'b0;
    #1;
    check("ifetch_miss_ctl", ctl(), 8'b0011_0101);

    // DWAIT: 4 frozen cycles then release on dhit
    do_reset();
    dmemREN_MEM = 1'b1;
    #1;
    check("dmiss_ctl", ctl(), 8'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dwait_ctl", ctl(), 8'b0);
    end
    tick();
    check("dwait_stall_cnt", stall_cycles, 4);
    dhit = 1'b1;
    #1;
    check("dwait_exit_ctl", ctl(), 8'b1101_0101);
    tick();
    dmemREN_MEM = 1'b0; dhit = 1'b0;
    #1;
    check("back_in_run", ctl(), 8'b1101_0101);
    check("dwait_stall_final", stall_cycles, 4);
    dhit = 1'b1;
    #1;
    check("dhit_no_access", ctl(), 8'b1101_0101);
    dhit = 1'b0;

    // branch beats load-use and fetch miss
    memtoReg_EX = 1'b1; final_wsel_EX = 5'd9; rs_ID = 5'd9; ihit = 1'b0;
    branch_taken_EX = 1'b1;
    #1;
    check("branch_ctl", ctl(), 8'b1010_1101);
    tick();
    check("branch_redirects", redirects, 1);
    check("branch_no_stall", stall_cycles, 4);

    // branch honoured on the DWAIT exit cycle
    idle();
    dmemWEN_MEM = 1'b1;
    tick();
    check("dwait_wen_ctl", ctl(), 8'b0);
    dhit = 1'b1; branch_taken_EX = 1'b1;
    #1;
    check("dwait_exit_branch", ctl(), 8'b1010_1101);
    tick();
    check("dwait_exit_redirects", redirects, 2);

    // halt coinciding with dhit: access completes, then HALT
    idle();
    dmemREN_MEM = 1'b1; dhit = 1'b1; halt_MEM = 1'b1;
    #1;
    check("halt_ctl", ctl(), 8'b0010_1011);
    check("halt_not_yet", halted, 0);
    tick();
    check("halt_stall_cnt", stall_cycles, 6);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; branch_taken_EX = i[1]; halt_MEM = i[2]; dhit = ~i[0];
      dmemREN_MEM = i[1]; memtoReg_EX = 1'b1; final_wsel_EX = 5'd4; rs_ID = 5'd4;
      #1;
      check("halted_flag", halted, 1);
      check("halted_ctl", ctl(), 8'b0);
      tick();
    end
    check("halt_stall_frozen", stall_cycles, 6);
    check("halt_redirects_frozen", redirects, 2);
    do_reset();
    check("halt_reset_run", ctl(), 8'b1101_0101);
    check("halt_reset_halted", halted, 0);
    check("halt_reset_cnt", stall_cycles, 0);
    check("halt_reset_redir", redirects, 0);

    // saturation at 2^4-1
    ihit = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("sat_reach", stall_cycles, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", stall_cycles, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
